// File: rtl/fm_ctrl_pkg.sv
// Shared state encodings and default widths for the FM transmit controller.
package fm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TX     = 2'd2,
        ST_HANG   = 2'd3
    } fm_state_e;

    localparam int DEF_INPUT_WIDTH   = 12;
    localparam int DEF_PHASE_WIDTH   = 32;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_HANG_CYCLES   = 64;
    localparam int DEF_STEP_SHIFT    = 20;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fm_slew.sv
// Slew limiter: moves current toward target by at most step, never overshooting.
module fm_slew #(
    parameter int W = 32
) (
    input  logic [W-1:0] target,
    input  logic [W-1:0] current,
    input  logic [W-1:0] step,
    output logic [W-1:0] next
);
    logic [W-1:0] diff;

    always_comb begin
        diff = '0;
        next = current;
        if (target >= current) begin
            diff = target - current;
            next = (diff > step) ? current + step : target;
        end else begin
            diff = current - target;
            next = (diff > step) ? current - step : target;
        end
    end
endmodule

// File: rtl/fm_tx_ctrl.sv
// Key-up/settle/transmit/hang sequencer feeding an FM modulator.
// Define FM_TX_CTRL_SLEW_EN to slew the carrier word instead of jumping it.
module fm_tx_ctrl
    import fm_ctrl_pkg::*;
#(
    parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
    parameter int PHASE_WIDTH   = DEF_PHASE_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int HANG_CYCLES   = DEF_HANG_CYCLES,
    parameter int STEP_SHIFT    = DEF_STEP_SHIFT
) (
    input  logic                               clk_in,
    input  logic                               RST,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [PHASE_WIDTH-1:0]             cfg_center,
    input  logic [PHASE_WIDTH-INPUT_WIDTH-1:0] cfg_dev,
    input  logic                               ptt_in,
    input  logic [INPUT_WIDTH-1:0]             wave_in,
    output logic [PHASE_WIDTH-1:0]             center_fre,
    output logic [PHASE_WIDTH-INPUT_WIDTH-1:0] move_fre,
    output logic [INPUT_WIDTH-1:0]             wave_out,
    output logic                               tx_en,
    output logic [1:0]                         state_o
);
    localparam int DW      = PHASE_WIDTH - INPUT_WIDTH;
    localparam int CNT_MAX = max_int(SETTLE_CYCLES, HANG_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HANG_LAST   = CW'(HANG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);

    if (STEP_SHIFT >= PHASE_WIDTH) begin : g_step_chk
        $error("STEP_SHIFT must be below PHASE_WIDTH");
    end

    fm_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [PHASE_WIDTH-1:0] tgt_center_q, tgt_center_d;
    logic [PHASE_WIDTH-1:0] center_q, center_d;
    logic [DW-1:0]          tgt_dev_q, tgt_dev_d, move_q, move_d;
    logic [INPUT_WIDTH-1:0] wave_q, wave_d;
    logic                   cfg_ready_q, cfg_ready_d, tx_en_q, tx_en_d;
    logic                   cfg_xfer, at_target;

`ifdef FM_TX_CTRL_SLEW_EN
    localparam logic [PHASE_WIDTH-1:0] STEP = PHASE_WIDTH'(1) << STEP_SHIFT;
    logic [PHASE_WIDTH-1:0] center_slew;

    fm_slew #(.W(PHASE_WIDTH)) u_slew (
        .target  (tgt_center_q),
        .current (center_q),
        .step    (STEP),
        .next    (center_slew)
    );
`endif

    assign cfg_xfer  = cfg_valid && cfg_ready_q;
    assign at_target = (center_q == tgt_center_q);
    assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_center_d = cfg_xfer ? cfg_center : tgt_center_q;
        tgt_dev_d    = cfg_xfer ? cfg_dev : tgt_dev_q;
        center_d     = center_q;
        case (state_q)
            ST_IDLE: begin
                if (ptt_in) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                // Settle time only accrues once the carrier word has arrived.
                if (!ptt_in) begin
                    state_d = ST_IDLE;
                end else if (at_target) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_TX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_TX: begin
                if (!ptt_in) begin
                    state_d = ST_HANG;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (ptt_in) begin
                    state_d = ST_TX;
                    cnt_d   = '0;
                end else if (cnt_q == HANG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
`ifdef FM_TX_CTRL_SLEW_EN
        if (state_q == ST_SETTLE) center_d = center_slew;
`else
        if (state_q == ST_IDLE && state_d == ST_SETTLE) center_d = tgt_center_d;
`endif
        move_d      = tgt_dev_q;
        wave_d      = (state_d == ST_TX) ? wave_in : '0;
        tx_en_d     = (state_d != ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tgt_center_q <= '0;
            tgt_dev_q    <= '0;
            center_q     <= '0;
            move_q       <= '0;
            wave_q       <= '0;
            tx_en_q      <= 1'b0;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tgt_center_q <= tgt_center_d;
            tgt_dev_q    <= tgt_dev_d;
            center_q     <= center_d;
            move_q       <= move_d;
            wave_q       <= wave_d;
            tx_en_q      <= tx_en_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign center_fre = center_q;
    assign move_fre   = move_q;
    assign wave_out   = wave_q;
    assign tx_en      = tx_en_q;
    assign state_o    = state_q;
endmodule

// File: doc/fm_tx_ctrl.md
FM_TX_CTRL -- requirements
Module: fm_tx_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, 12, audio sample width (signed).
REQ-002 SHALL have parameter PHASE_WIDTH, 32, frequency-word width.
REQ-003 SHALL have parameter SETTLE_CYCLES, 16, carrier-settle time before audio is unmuted.
REQ-004 SHALL have parameter HANG_CYCLES, 64, carrier hang time after PTT release.
REQ-005 SHALL have parameter STEP_SHIFT, 20, center-word slew step is 2^STEP_SHIFT per cycle.
REQ-006 SHALL have port clk_in  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-008 SHALL have port cfg_valid  in  1, cfg_ready  out  1: configuration handshake.
REQ-009 SHALL have port cfg_center  in  PHASE_WIDTH, target center frequency word.
REQ-010 SHALL have port cfg_dev  in  PHASE_WIDTH-INPUT_WIDTH, target deviation word.
REQ-011 SHALL have port ptt_in  in  1  push-to-talk level.
REQ-012 SHALL have port wave_in  in  INPUT_WIDTH  signed audio from source.
REQ-013 SHALL have ports center_fre  out  PHASE_WIDTH, move_fre  out  PHASE_WIDTH-INPUT_WIDTH, wave_out  out  INPUT_WIDTH: drive the FM modulator.
REQ-014 SHALL have ports tx_en  out  1 (carrier on), state_o  out  2 (current state encoding).

Function
REQ-015 SHALL implement states IDLE=0, SETTLE=1, TX=2, HANG=3.
REQ-016 cfg_ready SHALL be 1 only in IDLE; transfer occurs when cfg_valid&cfg_ready, latching cfg_center/cfg_dev into target registers; move_fre SHALL update to the latched dev the following cycle.
REQ-017 IDLE: tx_en=0, wave_out=0; ptt_in=1 -> SETTLE next cycle; a cfg transfer in the same cycle SHALL be latched first and used by that SETTLE.
REQ-018 SETTLE: tx_en=1, wave_out=0; center_fre moves toward target by min(|target-center_fre|, 2^STEP_SHIFT) per cycle, unsigned compare, never overshooting, no modular wrap.
REQ-019 SETTLE: counter starts at 0 on the first cycle center_fre==target; after SETTLE_CYCLES such cycles -> TX; ptt_in=0 at any SETTLE cycle -> IDLE next cycle.
REQ-020 TX: tx_en=1; wave_out = wave_in registered, latency 1 cycle; ptt_in=0 -> HANG.
REQ-021 HANG: tx_en=1, wave_out=0; counts HANG_CYCLES then -> IDLE; ptt_in=1 during HANG -> TX next cycle, counter cleared.
REQ-022 center_fre SHALL hold its value in IDLE (carrier word retained for next key-up).
REQ-023 Counters SHALL be sized $clog2(max+1) and saturate, never wrap.

Reset
REQ-024 RST=1 SHALL force IDLE, counters 0, targets 0, center_fre=0, move_fre=0, wave_out=0, tx_en=0, cfg_ready=0 during reset, 1 on first post-reset cycle.
REQ-025 RST mid-operation (any state) SHALL take effect next edge with no handshake completion.

Configuration
REQ-026 Macro FM_TX_CTRL_SLEW_EN defined: slewing per REQ-018.
REQ-027 Macro absent: center_fre SHALL equal target on the first SETTLE cycle; settle counter starts immediately; STEP_SHIFT unused.

Structure
REQ-028 Package fm_ctrl_pkg SHALL hold the state typedef/encodings and default width constants.
REQ-029 Slew limiter SHALL be a sub-module fm_slew (target, current, step -> next), instantiated only under FM_TX_CTRL_SLEW_EN.

Verification (SETTLE_CYCLES=4, HANG_CYCLES=8, STEP_SHIFT=20)
REQ-030 cfg 0x0400_0000/dev 0x100 then ptt=1 from center 0x0380_0000 (SLEW_EN): 8 slew cycles of +0x10_0000, then 4 settle cycles, then state_o=2, wave_out follows wave_in with 1-cycle delay.
REQ-031 ptt drops 2 cycles into SETTLE -> IDLE next cycle, tx_en=0, wave_out never nonzero.
REQ-032 TX, ptt low 3 cycles then high -> HANG for 3 cycles, back to TX, tx_en stays 1 throughout.
REQ-033 TX, ptt low -> 8 HANG cycles, then IDLE, tx_en=0, center_fre retained.
REQ-034 cfg_valid in SETTLE/TX -> cfg_ready=0, targets unchanged; cfg_valid with ptt rising in IDLE -> new target used.
REQ-035 RST pulse in TX -> all outputs 0, state_o=0 next cycle; macro absent: center_fre jumps to target in one cycle.
